dm_unit: RTL and testbench
==========================

DM_UNIT -- requirements
Module: dm_unit

Interface
REQ-001 The block SHALL take parameter DEPTH, default 256, giving the number of 32-bit words in the data array (power of two).
REQ-002 The block SHALL take parameter CNT_W, default 16, giving the width of the store counter.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset; it is asynchronous and active-high.
REQ-005 The block SHALL have port mem_w, input, 1, store strobe from the MEM stage.
REQ-006 The block SHALL have port dm_ctrl, input, 3, access size: 000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; other codes act as word.
REQ-007 The block SHALL have port addr, input, 32, byte address (the core's ALU result).
REQ-008 The block SHALL have port din, input, 32, store data, right-aligned.
REQ-009 The block SHALL have port dout, output, 32, load data, already extended; feeds the core's Data_in.
REQ-010 The block SHALL have port io_in, input, 32, external input word (see REQ-027).
REQ-011 The block SHALL have port io_out, output, 32, external output register (see REQ-027).
REQ-012 The block SHALL have port misalign_err, output, 1, sticky misaligned-store flag.
REQ-013 The block SHALL have port fault_addr, output, 32, address of the first misaligned store.
REQ-014 The block SHALL have port st_count, output, CNT_W, count of committed stores.

Function
REQ-015 Word index SHALL be addr[log2(DEPTH)+1:2]; higher address bits are ignored, so addresses wrap modulo 4*DEPTH bytes.
REQ-016 dout SHALL be combinational (zero-latency) from the addressed word, because the core samples it in the same cycle.
REQ-017 Byte loads SHALL select byte addr[1:0]; half loads SHALL select half addr[1]; result sign- or zero-extended per dm_ctrl.
REQ-018 Stores SHALL commit on the rising edge while mem_w=1, using byte enables: word = all four bytes; half = the two bytes at addr[1]; byte = the byte at addr[1:0]; data from din's low bits.
REQ-019 A store is misaligned when word and addr[1:0]!=0, or half and addr[0]=1; a misaligned store SHALL NOT modify any storage and SHALL NOT increment st_count.
REQ-020 On the first misaligned store, misalign_err SHALL set at that edge and fault_addr SHALL capture addr; later faults SHALL leave fault_addr unchanged.
REQ-021 st_count SHALL increment by one per committed store and saturate at all-ones.
REQ-022 Read-during-write to the same word: dout SHALL show old data in that cycle and new data from the next cycle.
REQ-023 Loads SHALL never be flagged misaligned; a misaligned half load returns bytes addr[1]*2 and +1 of the word, ignoring addr[0].

Reset
REQ-024 When rst asserts, misalign_err=0, fault_addr=0, st_count=0, io_out=0 immediately, without waiting for clk.
REQ-025 Array contents SHALL be unaffected by reset; a store coinciding with rst assertion SHALL NOT commit.

Configuration
REQ-026 Macro DM_MMIO_EN SHALL select memory-mapped I/O.
REQ-027 With DM_MMIO_EN defined: addresses with addr[31:28]=4'hF SHALL bypass the array; aligned word stores load io_out; loads return io_in with normal extraction; sub-word stores there count as misaligned.
REQ-028 Without DM_MMIO_EN: io_out SHALL be constant 0, io_in ignored, and all addresses map to the array per REQ-015.

Verification
REQ-029 Store word 0x8000_F0A1 at 0x10 -> next cycle, lb@0x10 = 0xFFFF_FFA1, lbu@0x11 = 0x0000_00F0, lh@0x12 = 0xFFFF_8000, st_count=1.
REQ-030 Store half 0xBEEF at 0x22 over word 0x1234_5678 at 0x20 -> lw@0x20 = 0xBEEF_5678.
REQ-031 Store word at 0x31, then half at 0x45 -> memory unchanged, misalign_err=1, fault_addr=0x31, st_count unchanged.
REQ-032 Assert rst mid-cycle after REQ-031 -> flags, fault_addr, st_count, io_out read 0 before next clk edge; earlier array data retained.
REQ-033 DEPTH=256: store at 0x400 -> lw@0x000 returns it (wrap); with DM_MMIO_EN, sw 0xA5A5_0001 at 0xF000_0000 -> io_out=0xA5A5_0001, array word 0 unchanged.

Source files
------------

// File: rtl/dm_unit.sv
// dm_unit: byte-addressable data memory for the core's MEM stage, with
// signed/unsigned sub-word loads, byte-enabled stores, a misaligned-store
// trap and a saturating count of committed stores.
// Optional feature macro: DM_MMIO_EN. When it is defined, addresses with
// addr[31:28] == 4'hF are routed to io_in/io_out instead of the array.
// Ports:
//   clk, rst      : clock (rising edge) and asynchronous active-high reset
//   mem_w         : store strobe from the MEM stage
//   dm_ctrl[2:0]  : access size (word / half s,u / byte s,u; others = word)
//   addr[31:0]    : byte address; din[31:0] : right-aligned store data
//   dout[31:0]    : combinational, already-extended load data
//   io_in, io_out : external input word / output register (MMIO build only)
//   misalign_err  : sticky flag; fault_addr : address of first bad store
//   st_count      : saturating count of committed stores
module dm_unit #(
  parameter int DEPTH = 256,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_w,
  input  logic [2:0]       dm_ctrl,
  input  logic [31:0]      addr,
  input  logic [31:0]      din,
  output logic [31:0]      dout,
  input  logic [31:0]      io_in,
  output logic [31:0]      io_out,
  output logic             misalign_err,
  output logic [31:0]      fault_addr,
  output logic [CNT_W-1:0] st_count
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [2:0] CTRL_HS = 3'b001;
  localparam logic [2:0] CTRL_HU = 3'b010;
  localparam logic [2:0] CTRL_BS = 3'b011;
  localparam logic [2:0] CTRL_BU = 3'b100;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Storage is kept as four byte lanes per word so byte enables map directly.
  logic [3:0][7:0]  r_mem [DEPTH];
  logic             r_misalign_err;
  logic [31:0]      r_fault_addr;
  logic [CNT_W-1:0] r_st_count;

  logic [AW-1:0]    w_idx;
  logic             w_mmio;
  logic             w_is_half;
  logic             w_is_byte;
  logic             w_is_word;
  logic             w_mis;
  logic             w_commit;
  logic [3:0][7:0]  w_rword;
  logic [7:0]       w_rbyte;
  logic [15:0]      w_rhalf;
  logic [3:0][7:0]  w_wdat;
  logic [3:0]       w_be;

  // Address bits above the array index are don't-care in the array path.
  logic             w_unused;
  assign w_unused = ^{addr[31:AW+2], io_in};

  assign w_idx = addr[AW+1:2];

`ifdef DM_MMIO_EN
  assign w_mmio  = (addr[31:28] == 4'hF);
  assign w_rword = w_mmio ? io_in : r_mem[w_idx];
`else
  assign w_mmio  = 1'b0;
  assign w_rword = r_mem[w_idx];
`endif

  assign w_is_half = (dm_ctrl == CTRL_HS) || (dm_ctrl == CTRL_HU);
  assign w_is_byte = (dm_ctrl == CTRL_BS) || (dm_ctrl == CTRL_BU);
  assign w_is_word = !w_is_half && !w_is_byte;

  // Loads never fault: a half load simply ignores addr[0].
  assign w_rbyte = w_rword[addr[1:0]];
  assign w_rhalf = addr[1] ? {w_rword[3], w_rword[2]} : {w_rword[1], w_rword[0]};

  always_comb begin
    dout = w_rword;
    case (dm_ctrl)
      CTRL_HS: dout = {{16{w_rhalf[15]}}, w_rhalf};
      CTRL_HU: dout = {16'h0000, w_rhalf};
      CTRL_BS: dout = {{24{w_rbyte[7]}}, w_rbyte};
      CTRL_BU: dout = {24'h000000, w_rbyte};
      default: dout = w_rword;
    endcase
  end

  // The I/O window only accepts aligned word stores; sub-word stores there
  // are treated as misaligned so they are trapped rather than dropped.
  assign w_mis = (w_is_word && (addr[1:0] != 2'b00))
               || (w_is_half && addr[0])
               || (w_mmio && !w_is_word);
  assign w_commit = mem_w && !w_mis;

  always_comb begin
    w_wdat = din;
    w_be   = 4'b1111;
    if (w_is_half) begin
      w_wdat = {din[15:0], din[15:0]};
      w_be   = addr[1] ? 4'b1100 : 4'b0011;
    end else if (w_is_byte) begin
      w_wdat = {4{din[7:0]}};
      w_be   = 4'b0001 << addr[1:0];
    end
  end

  // Array is not reset; a store sampled while rst is high is suppressed.
  always_ff @(posedge clk) begin
    if (w_commit && !w_mmio && !rst) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_idx][b] <= w_wdat[b];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_misalign_err <= 1'b0;
      r_fault_addr   <= 32'h0000_0000;
      r_st_count     <= '0;
    end else begin
      if (mem_w && w_mis && !r_misalign_err) begin
        r_misalign_err <= 1'b1;
        r_fault_addr   <= addr;
      end
      if (w_commit && (r_st_count != {CNT_W{1'b1}})) begin
        r_st_count <= r_st_count + CNT_ONE;
      end
    end
  end

`ifdef DM_MMIO_EN
  logic [31:0] r_io_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_io_out <= 32'h0000_0000;
    end else if (w_commit && w_mmio) begin
      r_io_out <= din;
    end
  end

  assign io_out = r_io_out;
`else
  assign io_out = 32'h0000_0000;
`endif

  assign misalign_err = r_misalign_err;
  assign fault_addr   = r_fault_addr;
  assign st_count     = r_st_count;

endmodule

// File: tb/tb_dm_unit.sv
// Self-checking bench for dm_unit: a table of load/store vectors followed by
// hand-written sequences for misaligned stores, mid-cycle reset, counter
// saturation and (when DM_MMIO_EN is defined) the I/O window.
module tb_dm_unit;
  localparam int DEPTH = 256;
  localparam int CNT_W = 4;

  localparam int K_DOUT  = 0;
  localparam int K_CNT   = 1;
  localparam int K_ERR   = 2;
  localparam int K_FAULT = 3;
  localparam int K_IO    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_w;
  logic [2:0]       dm_ctrl;
  logic [31:0]      addr;
  logic [31:0]      din;
  logic [31:0]      dout;
  logic [31:0]      io_in;
  logic [31:0]      io_out;
  logic             misalign_err;
  logic [31:0]      fault_addr;
  logic [CNT_W-1:0] st_count;

  always #5 clk = ~clk;

  dm_unit #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_w       (mem_w),
    .dm_ctrl     (dm_ctrl),
    .addr        (addr),
    .din         (din),
    .dout        (dout),
    .io_in       (io_in),
    .io_out      (io_out),
    .misalign_err(misalign_err),
    .fault_addr  (fault_addr),
    .st_count    (st_count)
  );

  typedef struct {
    logic             mw;
    logic [2:0]       ctrl;
    logic [31:0]      a;
    logic [31:0]      d;
    logic             chk_dout;
    logic [31:0]      exp_dout;
    logic [CNT_W-1:0] exp_cnt;
  } vec_t;

  typedef struct {
    int          kind;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs [18];
  sb_t  sb_q [$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic string kname(input int k);
    case (k)
      K_DOUT:  return "dout";
      K_CNT:   return "st_count";
      K_ERR:   return "misalign_err";
      K_FAULT: return "fault_addr";
      default: return "io_out";
    endcase
  endfunction

  function automatic logic [31:0] actual(input int k);
    case (k)
      K_DOUT:  return dout;
      K_CNT:   return {{(32-CNT_W){1'b0}}, st_count};
      K_ERR:   return {31'h0, misalign_err};
      K_FAULT: return fault_addr;
      default: return io_out;
    endcase
  endfunction

  task automatic expect_val(input int k, input logic [31:0] v);
    sb_t e;
    e.kind = k;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic drain(input string tag);
    sb_t e;
    logic [31:0] a;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      a = actual(e.kind);
      n_checks++;
      if (a !== e.exp) begin
        n_fail++;
        $display("FAIL %s.%s: got %h expected %h", tag, kname(e.kind), a, e.exp);
      end
    end
  endtask

  task automatic drive(input logic mw, input logic [2:0] c,
                       input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    mem_w   = mw;
    dm_ctrl = c;
    addr    = a;
    din     = d;
  endtask

  task automatic sample(input string tag);
    #2;
    drain(tag);
  endtask

  function automatic void set_vec(input int i, input logic mw, input logic [2:0] c,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic chk, input logic [31:0] ed,
                                  input logic [CNT_W-1:0] ec);
    vecs[i].mw       = mw;
    vecs[i].ctrl     = c;
    vecs[i].a        = a;
    vecs[i].d        = d;
    vecs[i].chk_dout = chk;
    vecs[i].exp_dout = ed;
    vecs[i].exp_cnt  = ec;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [CNT_W-1:0] m_cnt;

    // Each entry: st_count is the value seen before this vector's store commits.
    set_vec( 0, 1, 3'd0, 32'h10,  32'h8000_F0A1, 0, 32'h0,         0);
    set_vec( 1, 0, 3'd3, 32'h10,  32'h0,         1, 32'hFFFF_FFA1, 1);
    set_vec( 2, 0, 3'd4, 32'h11,  32'h0,         1, 32'h0000_00F0, 1);
    set_vec( 3, 0, 3'd1, 32'h12,  32'h0,         1, 32'hFFFF_8000, 1);
    set_vec( 4, 0, 3'd2, 32'h12,  32'h0,         1, 32'h0000_8000, 1);
    set_vec( 5, 0, 3'd0, 32'h10,  32'h0,         1, 32'h8000_F0A1, 1);
    set_vec( 6, 1, 3'd0, 32'h20,  32'h1234_5678, 0, 32'h0,         1);
    set_vec( 7, 1, 3'd2, 32'h22,  32'hFFFF_BEEF, 1, 32'h0000_1234, 2);
    set_vec( 8, 0, 3'd0, 32'h20,  32'h0,         1, 32'hBEEF_5678, 3);
    set_vec( 9, 1, 3'd3, 32'h13,  32'h1234_56AA, 1, 32'hFFFF_FF80, 3);
    set_vec(10, 0, 3'd0, 32'h10,  32'h0,         1, 32'hAA00_F0A1, 4);
    set_vec(11, 0, 3'd1, 32'h13,  32'h0,         1, 32'hFFFF_AA00, 4);
    set_vec(12, 0, 3'd0, 32'h410, 32'h0,         1, 32'hAA00_F0A1, 4);
    set_vec(13, 1, 3'd0, 32'h400, 32'hCAFE_F00D, 0, 32'h0,         4);
    set_vec(14, 0, 3'd0, 32'h0,   32'h0,         1, 32'hCAFE_F00D, 5);
    set_vec(15, 0, 3'd7, 32'h20,  32'h0,         1, 32'hBEEF_5678, 5);
    set_vec(16, 1, 3'd5, 32'h20,  32'h1122_3344, 1, 32'hBEEF_5678, 5);
    set_vec(17, 0, 3'd0, 32'h20,  32'h0,         1, 32'h1122_3344, 6);

    rst     = 1'b1;
    mem_w   = 1'b0;
    dm_ctrl = 3'd0;
    addr    = 32'h0;
    din     = 32'h0;
    io_in   = 32'h1234_ABCD;

    repeat (2) @(negedge clk);
    expect_val(K_CNT, 32'h0);
    expect_val(K_ERR, 32'h0);
    expect_val(K_FAULT, 32'h0);
    expect_val(K_IO, 32'h0);
    sample("reset");
    rst = 1'b0;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].mw, vecs[i].ctrl, vecs[i].a, vecs[i].d);
      if (vecs[i].chk_dout) expect_val(K_DOUT, vecs[i].exp_dout);
      expect_val(K_CNT, {{(32-CNT_W){1'b0}}, vecs[i].exp_cnt});
      expect_val(K_ERR, 32'h0);
      sample($sformatf("vec%0d", i));
    end

    // Misaligned stores: no storage change, no count, first address latched.
    drive(1, 3'd0, 32'h30, 32'h5566_7788);
    sample("sw30");
    drive(1, 3'd0, 32'h44, 32'h0BAD_F00D);
    sample("sw44");
    drive(1, 3'd0, 32'h31, 32'hDEAD_BEEF);
    expect_val(K_DOUT, 32'h5566_7788);
    expect_val(K_CNT, 32'd8);
    expect_val(K_ERR, 32'h0);
    sample("sw31");
    drive(0, 3'd0, 32'h30, 32'h0);
    expect_val(K_DOUT, 32'h5566_7788);
    expect_val(K_ERR, 32'h1);
    expect_val(K_FAULT, 32'h31);
    expect_val(K_CNT, 32'd8);
    sample("after_sw31");
    drive(1, 3'd1, 32'h45, 32'h0000_1111);
    sample("sh45");
    drive(0, 3'd0, 32'h44, 32'h0);
    expect_val(K_DOUT, 32'h0BAD_F00D);
    expect_val(K_ERR, 32'h1);
    expect_val(K_FAULT, 32'h31);
    expect_val(K_CNT, 32'd8);
    sample("after_sh45");

`ifdef DM_MMIO_EN
    drive(1, 3'd0, 32'hF000_0000, 32'hA5A5_0001);
    sample("mmio_sw");
    drive(0, 3'd0, 32'h0, 32'h0);
    expect_val(K_DOUT, 32'hCAFE_F00D);
    expect_val(K_IO, 32'hA5A5_0001);
    expect_val(K_CNT, 32'd9);
    sample("mmio_after_sw");
    drive(1, 3'd1, 32'hF000_0000, 32'h0000_7777);
    sample("mmio_sh");
    drive(0, 3'd4, 32'hF000_0001, 32'h0);
    expect_val(K_DOUT, 32'h0000_00AB);
    expect_val(K_IO, 32'hA5A5_0001);
    expect_val(K_CNT, 32'd9);
    expect_val(K_FAULT, 32'h31);
    sample("mmio_lbu");
`endif

    // Reset asserted mid-cycle with a store pending: outputs clear at once,
    // the store is dropped, array contents survive.
    drive(1, 3'd0, 32'h30, 32'hFFFF_FFFF);
    #2;
    rst = 1'b1;
    #1;
    expect_val(K_ERR, 32'h0);
    expect_val(K_FAULT, 32'h0);
    expect_val(K_CNT, 32'h0);
    expect_val(K_IO, 32'h0);
    drain("midreset");
    @(negedge clk);
    rst   = 1'b0;
    mem_w = 1'b0;
    drive(0, 3'd0, 32'h30, 32'h0);
    expect_val(K_DOUT, 32'h5566_7788);
    expect_val(K_CNT, 32'h0);
    sample("post_reset30");
    drive(0, 3'd0, 32'h10, 32'h0);
    expect_val(K_DOUT, 32'hAA00_F0A1);
    sample("post_reset10");

    // Counter saturation at all-ones.
    m_cnt = '0;
    for (int i = 0; i < 20; i++) begin
      drive(1, 3'd0, 32'h50, i);
      expect_val(K_CNT, {{(32-CNT_W){1'b0}}, m_cnt});
      sample($sformatf("sat%0d", i));
      if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
    end
    drive(0, 3'd0, 32'h50, 32'h0);
    expect_val(K_DOUT, 32'd19);
    expect_val(K_CNT, {{(32-CNT_W){1'b0}}, {CNT_W{1'b1}}});
    sample("sat_final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
